// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
// Loads hit in one cycle. Load misses refill a whole line in ascending beats.
// Stores always go to memory; on a hit they also update the cached line.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters
// (statHits, statMisses).
module dcache_dm #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpuReq,
  input  logic                cpuWe,
  input  logic [ADDR_W-1:0]   cpuAddr,
  input  logic [DATA_W-1:0]   cpuWdata,
  input  logic [DATA_W/8-1:0] cpuByteEn,
  input  logic                cpuFlush,
  output logic                cpuReady,
  output logic                cpuRvalid,
  output logic [DATA_W-1:0]   cpuRdata,
  output logic                cpuWdone,
  output logic                memReq,
  output logic                memWe,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  output logic [DATA_W/8-1:0] memByteEn,
  input  logic                memReady,
  input  logic                memRvalid,
  input  logic [DATA_W-1:0]   memRdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         statHits,
  output logic [31:0]         statMisses
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_DATA, RESP, WRITE_MEM} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [NB-1:0]     ben_reg;
  logic [OFF_W-1:0]  beat_reg;
  logic [DATA_W-1:0] resp_reg;
  logic              hit_rvalid_reg;
  logic [LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [DATA_W-1:0] rd_word;
  logic              resp_valid;

  // Address split of the incoming request and of the latched request
  logic [OFF_W-1:0] cpu_off, lat_off;
  logic [IDX_W-1:0] cpu_idx, lat_idx;
  logic [TAG_W-1:0] cpu_tag, lat_tag;
  logic [IDX_W+OFF_W-1:0] cpu_word, refill_word;

  assign cpu_off     = cpuAddr[OFF_W-1:0];
  assign cpu_idx     = cpuAddr[OFF_W +: IDX_W];
  assign cpu_tag     = cpuAddr[ADDR_W-1 -: TAG_W];
  assign lat_off     = addr_reg[OFF_W-1:0];
  assign lat_idx     = addr_reg[OFF_W +: IDX_W];
  assign lat_tag     = addr_reg[ADDR_W-1 -: TAG_W];
  assign cpu_word    = {cpu_idx, cpu_off};
  assign refill_word = {lat_idx, beat_reg};

  logic accept, hit, load_hit, store_hit, beat_fire, last_beat;

  assign accept    = cpuReq && (state_reg == IDLE);
  assign hit       = valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign load_hit  = accept && !cpuWe && hit;
  assign store_hit = accept && cpuWe && hit;
  assign beat_fire = (state_reg == REFILL_DATA) && memRvalid;
  assign last_beat = beat_fire && (beat_reg == LAST_BEAT);

  // Data array split into byte lanes so store hits can write single bytes
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [LINES*WORDS];
    logic [7:0] rd_byte_reg;

    // Refill beats write every lane; store hits only the enabled lanes
    always_ff @(posedge clk) begin
      if (beat_fire)
        lane_mem[refill_word] <= memRdata[gi*8 +: 8];
      else if (store_hit && cpuByteEn[gi])
        lane_mem[cpu_word] <= cpuWdata[gi*8 +: 8];
      if (load_hit)
        rd_byte_reg <= lane_mem[cpu_word];
    end

    assign rd_word[gi*8 +: 8] = rd_byte_reg;
  end

  // Tag is written once the last beat of the line has landed
  always_ff @(posedge clk) begin
    if (last_beat)
      tag_mem[lat_idx] <= lat_tag;
  end

  // Control state, request latch, valid bits and refill beat tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ben_reg        <= '0;
      beat_reg       <= '0;
      resp_reg       <= '0;
      hit_rvalid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hit_rvalid_reg <= load_hit;
      if (accept) begin
        addr_reg  <= cpuAddr;
        wdata_reg <= cpuWdata;
        ben_reg   <= cpuByteEn;
      end
      if (state_reg == IDLE && !cpuReq && cpuFlush)
        valid_reg <= '0;
      else if (last_beat)
        valid_reg[lat_idx] <= 1'b1;
      if (state_reg == REFILL_REQ)
        beat_reg <= '0;
      else if (beat_fire)
        beat_reg <= beat_reg + 1'b1;
      // Capture the requested word as it streams past; avoids re-reading the array
      if (beat_fire && beat_reg == lat_off)
        resp_reg <= memRdata;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    cpuReady   = 1'b0;
    cpuWdone   = 1'b0;
    resp_valid = 1'b0;
    memReq     = 1'b0;
    memWe      = 1'b0;
    memAddr    = '0;
    memWdata   = '0;
    memByteEn  = '0;
    case (state_reg)
      IDLE: begin
        cpuReady = 1'b1;
        if (cpuReq) begin
          if (cpuWe)     state_next = WRITE_MEM;
          else if (!hit) state_next = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        memReq  = 1'b1;
        memAddr = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (memReady) state_next = REFILL_DATA;
      end
      REFILL_DATA: begin
        if (last_beat) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      WRITE_MEM: begin
        memReq    = 1'b1;
        memWe     = 1'b1;
        memAddr   = addr_reg;
        memWdata  = wdata_reg;
        memByteEn = ben_reg;
        if (memReady) begin
          cpuWdone   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpuRvalid = hit_rvalid_reg || resp_valid;
  assign cpuRdata  = hit_rvalid_reg ? rd_word : (resp_valid ? resp_reg : '0);

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters, bumped once per accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statHits   <= '0;
      statMisses <= '0;
    end else if (accept) begin
      if (hit) begin
        if (statHits != 32'hFFFF_FFFF) statHits <= statHits + 32'd1;
      end else begin
        if (statMisses != 32'hFFFF_FFFF) statMisses <= statMisses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed bench for dcache_dm with a transaction-level model.
// The model treats the cache as transparent (a load returns whatever the
// program last stored at that address) and tracks which line each slot holds
// to predict hit/miss latency. A memory stub answers the memory port.
module tb_dcache_dm;
  localparam int AW = 30, DW = 32, LINES = 16, WORDS = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cpuReq = 0, cpuWe = 0, cpuFlush = 0;
  logic [AW-1:0] cpuAddr = '0;
  logic [DW-1:0] cpuWdata = '0;
  logic [3:0]    cpuByteEn = '0;
  logic          cpuReady, cpuRvalid, cpuWdone, memReq, memWe;
  logic [DW-1:0] cpuRdata, memWdata;
  logic [AW-1:0] memAddr;
  logic [3:0]    memByteEn;
  logic          memReady = 0, memRvalid = 0;
  logic [DW-1:0] memRdata = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0]   statHits, statMisses;
`endif

  dcache_dm #(.ADDR_W(AW), .DATA_W(DW), .LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
    .cpuWdata(cpuWdata), .cpuByteEn(cpuByteEn), .cpuFlush(cpuFlush),
    .cpuReady(cpuReady), .cpuRvalid(cpuRvalid), .cpuRdata(cpuRdata), .cpuWdone(cpuWdone),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memByteEn(memByteEn), .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata)
`ifdef DCACHE_STATS_EN
    , .statHits(statHits), .statMisses(statMisses)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t rq[$];
  int   wq[$];
  logic [31:0] last_rdata = '0;
  logic [31:0] ref_mem [int];
  logic [31:0] bmem [int];
  logic        res_valid [LINES];
  int          res_line [LINES];
  int          exp_hits = 0, exp_misses = 0;

  function automatic logic [31:0] default_word(input logic [AW-1:0] a);
    if (a[7:4] == 4'h1) return 32'hA0 + {28'h0, a[3:0]};
    return {8'h5A, a[23:0]};
  endfunction
  function automatic logic [31:0] rd_ref(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return default_word(a);
  endfunction
  function automatic logic [31:0] rd_bmem(input logic [AW-1:0] a);
    if (bmem.exists(int'(a))) return bmem[int'(a)];
    return default_word(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction
  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) res_valid[i] = 1'b0;
  endfunction

  // Compare process: every cycle, load data/strobes must match the model's schedule
  always @(negedge clk) begin
    if (rst_n) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        check("rvalid", 32'(cpuRvalid), 32'd1);
        check("rdata", cpuRdata, rq[0].data);
        last_rdata = cpuRdata;
        void'(rq.pop_front());
      end else begin
        check("no_rvalid", 32'(cpuRvalid), 32'd0);
        check("rdata_idle", cpuRdata, 32'd0);
      end
      if (wq.size() > 0 && wq[0] == cyc) begin
        check("wdone", 32'(cpuWdone), 32'd1);
        void'(wq.pop_front());
      end else begin
        check("no_wdone", 32'(cpuWdone), 32'd0);
      end
    end
  end

  // ---------------- memory stub ----------------
  int          mem_delay = 0, wait_cnt = 0, beats_left = 0, req_count = 0;
  logic        hs = 0, pend = 0, req_we = 0;
  logic [AW-1:0] beat_addr = '0, req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  // Drives the memory side just after each edge so outputs are stable mid-cycle
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      memReady = 0; memRvalid = 0; memRdata = '0;
      beats_left = 0; hs = 0; pend = 0; wait_cnt = 0;
    end else begin
      if (hs) begin
        hs = 0; pend = 0;
        if (req_we) bmem[int'(req_addr)] = merge(rd_bmem(req_addr), req_wdata, req_be);
        else begin beats_left = WORDS; beat_addr = req_addr; end
      end
      if (beats_left > 0) begin
        memRvalid = 1; memRdata = rd_bmem(beat_addr); beat_addr++; beats_left--;
      end else begin
        memRvalid = 0; memRdata = '0;
      end
      memReady = 0;
      if (pend && !memReq) begin
        check("memreq_held", 32'(memReq), 32'd1);
        pend = 0;
      end
      if (memReq) begin
        if (!pend) begin
          pend = 1; wait_cnt = 0; req_count++;
          req_addr = memAddr; req_we = memWe; req_wdata = memWdata; req_be = memByteEn;
        end else begin
          check("hold_addr", 32'(memAddr), 32'(req_addr));
          check("hold_we", 32'(memWe), 32'(req_we));
        end
        if (wait_cnt >= mem_delay) begin memReady = 1; hs = 1; end
        else wait_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Presents one request at a negedge, records the model's expectation, returns
  // at the negedge after acceptance with the expected number of busy cycles.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output int busy);
    int n = 0, idx, line, acc;
    logic h;
    while (!cpuReady && n < 100) begin @(negedge clk); n++; end
    check("ready_before_issue", 32'(cpuReady), 32'd1);
    line = int'(a) / WORDS;
    idx  = line % LINES;
    h    = res_valid[idx] && res_line[idx] == line;
    acc  = cyc + 1;
    if (h) exp_hits++; else exp_misses++;
    if (!we) begin
      if (h) begin rq.push_back('{acc, rd_ref(a)}); busy = 0; end
      else begin
        rq.push_back('{acc + WORDS + 1 + mem_delay, rd_ref(a)});
        busy = WORDS + 2 + mem_delay;
        res_valid[idx] = 1'b1; res_line[idx] = line;
      end
    end else begin
      wq.push_back(acc + mem_delay);
      busy = 1 + mem_delay;
      ref_mem[int'(a)] = merge(rd_ref(a), wd, be);
    end
    cpuReq = 1; cpuWe = we; cpuAddr = a; cpuWdata = wd; cpuByteEn = be;
    @(posedge clk);
    @(negedge clk);
    cpuReq = 0; cpuWe = 0; cpuWdata = '0; cpuByteEn = '0;
  endtask

  task automatic wait_idle(input int busy_exp, input string name);
    int n = 0;
    while (!cpuReady && n < 200) begin @(negedge clk); n++; end
    check({name, "_busy"}, 32'(n), 32'(busy_exp));
    @(negedge clk);
    check({name, "_drain"}, 32'(rq.size() + wq.size()), 32'd0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_ready"}, 32'(cpuReady), 32'd1);
    check({name, "_rvalid"}, 32'(cpuRvalid), 32'd0);
    check({name, "_rdata"}, cpuRdata, 32'd0);
    check({name, "_wdone"}, 32'(cpuWdone), 32'd0);
    check({name, "_memreq"}, 32'(memReq), 32'd0);
    check({name, "_memwe"}, 32'(memWe), 32'd0);
    check({name, "_memaddr"}, 32'(memAddr), 32'd0);
    check({name, "_memwdata"}, memWdata, 32'd0);
    check({name, "_membe"}, 32'(memByteEn), 32'd0);
`ifdef DCACHE_STATS_EN
    check({name, "_stathits"}, statHits, 32'd0);
    check({name, "_statmisses"}, statMisses, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy, n0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst_n = 1;
    @(negedge clk);

    // 1: cold load, zero-wait refill
    issue(0, 30'h10, 32'h0, 4'h0, busy);
    wait_idle(busy, "t1");
    check("t1_data", last_rdata, 32'h0000_00A0);
    check("t1_memaddr", 32'(req_addr), 32'h10);
    check("t1_memwe", 32'(req_we), 32'd0);

    // 2: hit in the refilled line, no memory traffic
    n0 = req_count;
    issue(0, 30'h13, 32'h0, 4'h0, busy);
    wait_idle(busy, "t2");
    check("t2_data", last_rdata, 32'h0000_00A3);
    check("t2_no_mem", 32'(req_count), 32'(n0));

    // 3: store hit, write-through with byte enables
    issue(1, 30'h11, 32'hDEAD_BEEF, 4'b0011, busy);
    wait_idle(busy, "t3");
    check("t3_addr", 32'(req_addr), 32'h11);
    check("t3_we", 32'(req_we), 32'd1);
    check("t3_wdata", req_wdata, 32'hDEAD_BEEF);
    check("t3_be", 32'(req_be), 32'h3);
`ifdef DCACHE_STATS_EN
    check("t3_stathits", statHits, 32'd2);
    check("t3_statmisses", statMisses, 32'd1);
`endif
    issue(0, 30'h11, 32'h0, 4'h0, busy);
    wait_idle(busy, "t3ld");
    check("t3_merged", last_rdata, 32'h0000_BEEF);

    // 4: store miss does not allocate; original line still hits (back to back)
    n0 = req_count;
    issue(1, 30'h50, 32'h1234_5678, 4'hF, busy);
    wait_idle(busy, "t4st");
    issue(0, 30'h10, 32'h0, 4'h0, busy);
    issue(0, 30'h12, 32'h0, 4'h0, busy);
    wait_idle(busy, "t4ld");
    check("t4_hit_data", last_rdata, 32'h0000_00A2);
    check("t4_one_memop", 32'(req_count), 32'(n0 + 1));
    issue(0, 30'h50, 32'h0, 4'h0, busy);
    wait_idle(busy, "t4miss");
    check("t4_written", last_rdata, 32'h1234_5678);

    // request beats a simultaneous flush
    cpuFlush = 1;
    issue(0, 30'h50, 32'h0, 4'h0, busy);
    cpuFlush = 0;
    wait_idle(busy, "prio");
    issue(0, 30'h51, 32'h0, 4'h0, busy);
    wait_idle(busy, "prio2");

    // 5: flush, then refill with memReady held off 5 cycles
    cpuFlush = 1;
    @(negedge clk);
    cpuFlush = 0;
    model_clear();
    mem_delay = 5;
    issue(0, 30'h10, 32'h0, 4'h0, busy);
    wait_idle(busy, "t5");
    mem_delay = 0;
    check("t5_data", last_rdata, 32'h0000_00A0);
    check("t5_memaddr", 32'(req_addr), 32'h10);

    // 6: reset after two refill beats, then a clean refill
    issue(0, 30'h20, 32'h0, 4'h0, busy);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    rq.delete(); wq.delete(); model_clear();
    exp_hits = 0; exp_misses = 0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(0, 30'h20, 32'h0, 4'h0, busy);
    wait_idle(busy, "t6");
    check("t6_data", last_rdata, 32'h5A00_0020);
    issue(0, 30'h10, 32'h0, 4'h0, busy);
    wait_idle(busy, "t6b");
    check("t6b_data", last_rdata, 32'h0000_00A0);
`ifdef DCACHE_STATS_EN
    check("end_stathits", statHits, 32'(exp_hits));
    check("end_statmisses", statMisses, 32'(exp_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised, direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline memory stage and a shared backing-memory port.
- Replaces the flat single-cycle data array with tagged lines, byte-enable writes, multi-beat line refill and a ready/valid handshake on both sides.
- Stalls the pipeline via cpuReady while a miss or write-through is outstanding.

Parameters:
- ADDR_W, 30: word address width (byte address bits [31:2]).
- DATA_W, 32: data word width; must be a multiple of 8.
- LINES, 16: number of cache lines; power of 2, >=2.
- WORDS, 4: words per line; power of 2, >=2; equals refill beat count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpuReq  in  1  request valid; accepted when cpuReq && cpuReady.
- cpuWe  in  1  1 = store, 0 = load.
- cpuAddr  in  ADDR_W  word address.
- cpuWdata  in  DATA_W  store data.
- cpuByteEn  in  DATA_W/8  store byte enables; ignored on loads.
- cpuFlush  in  1  invalidate all lines; honoured only in IDLE when no request is accepted.
- cpuReady  out  1  high only in IDLE.
- cpuRvalid  out  1  one-cycle pulse with load data.
- cpuRdata  out  DATA_W  load data; valid only while cpuRvalid=1, otherwise 0.
- cpuWdone  out  1  one-cycle pulse when a store is accepted by memory.
- memReq  out  1  memory request valid; held until memReady.
- memWe  out  1  1 = single-word write, 0 = line read.
- memAddr  out  ADDR_W  word address; line-aligned (offset bits 0) for reads.
- memWdata  out  DATA_W  write data.
- memByteEn  out  DATA_W/8  write byte enables.
- memReady  in  1  memory accepts the request in the cycle memReq && memReady.
- memRvalid  in  1  refill beat valid.
- memRdata  in  DATA_W  refill beat data; beats arrive in ascending word order.

Behaviour:
- Address split: offset = low log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining bits.
- Storage: data array LINES*WORDS words, tag array, valid bit per line.
- Reset (async, rst_n=0):
  - All valid bits 0; FSM to IDLE.
  - Outputs: cpuReady=1, cpuRvalid=0, cpuRdata=0, cpuWdone=0, memReq=0, memWe=0, memAddr=0, memWdata=0, memByteEn=0.
  - Data and tag contents are not reset.
- States: IDLE, REFILL_REQ, REFILL_DATA, RESP, WRITE_MEM.
- IDLE, load hit (valid && tag match): cpuRvalid=1 and cpuRdata=word on the next cycle; stay in IDLE. Latency 1, back-to-back hits at 1 per cycle.
- IDLE, load miss: latch address. Next cycle go to REFILL_REQ with memReq=1, memWe=0, memAddr=line base.
- REFILL_REQ: hold outputs stable until memReady, then go to REFILL_DATA with beat counter 0.
- REFILL_DATA:
  - Each memRvalid writes memRdata to word[counter] and increments the counter.
  - Cycles without memRvalid do nothing.
  - After beat WORDS-1: write tag, set valid, go to RESP.
- RESP: cpuRvalid=1, cpuRdata = requested word from the refilled line; return to IDLE.
- Load miss latency with a zero-wait memory: 1 (req) + WORDS beats + 1 (RESP) after acceptance.
- IDLE, store:
  - On hit, merge cpuWdata into the line in the acceptance cycle using byte enables.
  - On miss, the cache is unchanged (no allocate).
  - Latch address, data and byte enables; go to WRITE_MEM with memReq=1, memWe=1.
- WRITE_MEM: hold until memReady; in that cycle cpuWdone=1, then go to IDLE.
- Request while not in IDLE: not accepted; the requester must hold it.
- Flush: in IDLE with cpuReq=0 and cpuFlush=1, all valid bits clear at the next edge. cpuReq has priority over cpuFlush.
- memRvalid outside REFILL_DATA: ignored.
- memReady without memReq: ignored.
- Reset during a refill: the partial line is discarded (valid cleared), and no response is issued for the aborted request.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds outputs statHits (32) and statMisses (32), both reset to 0.
  - statHits increments on every accepted load hit or store hit.
  - statMisses increments on every accepted load miss or store miss.
  - Both saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold load at 0x10, zero-wait memory returning 0xA0..0xA3 -> memReq with memAddr=0x10, memWe=0; cpuRvalid with cpuRdata=0xA0 exactly WORDS+2 cycles after acceptance; cpuReady=0 throughout.
- Load 0x13 right after that refill -> hit; cpuRvalid the next cycle with 0xA3; no memReq.
- Store 0x11, data 0xDEADBEEF, byteEn 4'b0011 (hit) -> memReq/memWe with the same address, data and byteEn; cpuWdone on memReady. A following load of 0x11 returns 0x0000BEEF-merged word (0xA1 upper bytes kept).
- Store to 0x50 (miss, same index as 0x10 with LINES=16) -> memory write only; a load of 0x10 still hits with the original line.
- Pulse cpuFlush in IDLE, then load 0x10 -> miss and a new refill; with memReady delayed 5 cycles, memReq and memAddr are held stable for all 5 cycles.
- Assert rst_n=0 after 2 refill beats, release it, then load the same address -> full new refill, no stale cpuRvalid. With DCACHE_STATS_EN defined, after scenarios 1–3 statHits=2 and statMisses=1.
